// File: rtl/mult_sched.sv
// Issue arbiter and writeback tag tracker for a shared pipelined multiplier.
// Optional build macro MULT_SCHED_FIXED_PRIO_EN makes port 0 always win contention.
module mult_sched #(
    parameter int MULT_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       req0_valid_i,
    input  logic [4:0] req0_tag_i,
    output logic       req0_ready_o,
    input  logic       req1_valid_i,
    input  logic [4:0] req1_tag_i,
    output logic       req1_ready_o,
    input  logic       hold_i,
    output logic       mul_valid_o,
    output logic       mul_sel_o,
    output logic       wb_valid_o,
    output logic       wb_port_o,
    output logic [4:0] wb_tag_o,
    output logic       busy_o
);

    typedef struct packed {
        logic       valid;
        logic       port;
        logic [4:0] tag;
    } entry_t;

    entry_t     pipe_q [MULT_STAGES];
    logic [1:0] cnt_q, cnt_d;
    logic       sel_q;
    logic       prio;
    logic       gnt_v, gnt_p;
    logic [4:0] gnt_tag;
    logic       retire;

`ifdef MULT_SCHED_FIXED_PRIO_EN
    assign prio = 1'b0;
`else
    logic prio_q, prio_d;

    assign prio   = prio_q;
    assign prio_d = gnt_v ? ~gnt_p : prio_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end
`endif

    // Grants are suppressed while in reset so every output reads 0 then.
    always_comb begin
        gnt_v = 1'b0;
        gnt_p = 1'b0;
        if (rstn_i && !hold_i) begin
            if (req0_valid_i && req1_valid_i) begin
                gnt_v = 1'b1;
                gnt_p = prio;
            end else if (req0_valid_i) begin
                gnt_v = 1'b1;
            end else if (req1_valid_i) begin
                gnt_v = 1'b1;
                gnt_p = 1'b1;
            end
        end
    end

    assign gnt_tag      = gnt_p ? req1_tag_i : req0_tag_i;
    assign req0_ready_o = gnt_v && !gnt_p;
    assign req1_ready_o = gnt_v && gnt_p;
    assign mul_valid_o  = gnt_v;
    assign mul_sel_o    = gnt_v ? gnt_p : sel_q;

    assign retire = pipe_q[MULT_STAGES-1].valid && !hold_i;

    always_comb begin
        cnt_d = cnt_q;
        unique case ({gnt_v, retire})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < MULT_STAGES; i++) begin
                pipe_q[i] <= '0;
            end
            cnt_q <= 2'd0;
            sel_q <= 1'b0;
        end else begin
            if (!hold_i) begin
                pipe_q[0] <= '{valid: gnt_v, port: gnt_p, tag: gnt_tag};
                for (int i = 1; i < MULT_STAGES; i++) begin
                    pipe_q[i] <= pipe_q[i-1];
                end
            end
            cnt_q <= cnt_d;
            sel_q <= mul_sel_o;
        end
    end

    assign wb_valid_o = pipe_q[MULT_STAGES-1].valid;
    assign wb_port_o  = pipe_q[MULT_STAGES-1].port;
    assign wb_tag_o   = pipe_q[MULT_STAGES-1].tag;
    assign busy_o     = (cnt_q != 2'd0);

endmodule

// File: tb/tb_mult_sched.sv
// Scoreboard bench for mult_sched: 2-stage and 3-stage instances share one stimulus stream.
module tb_mult_sched;

`ifdef MULT_SCHED_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       v0 = 1'b0, v1 = 1'b0, hold = 1'b0;
    logic [4:0] t0 = 5'd0, t1 = 5'd0;

    logic [1:0] r0_w, r1_w, mv_w, ms_w, wv_w, wp_w, bz_w;
    logic [4:0] wt_w [2];

    typedef struct {
        logic       port;
        logic [4:0] tag;
        int         nh;
    } wb_t;

    logic gq  [2][$];
    wb_t  wbq [2][$];
    int   m   [2];
    logic last_sel [2];
    int   nh = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mult_sched #(.MULT_STAGES(2)) u_dut2 (
        .clk_i(clk), .rstn_i(rstn),
        .req0_valid_i(v0), .req0_tag_i(t0), .req0_ready_o(r0_w[0]),
        .req1_valid_i(v1), .req1_tag_i(t1), .req1_ready_o(r1_w[0]),
        .hold_i(hold), .mul_valid_o(mv_w[0]), .mul_sel_o(ms_w[0]),
        .wb_valid_o(wv_w[0]), .wb_port_o(wp_w[0]), .wb_tag_o(wt_w[0]),
        .busy_o(bz_w[0])
    );

    mult_sched #(.MULT_STAGES(3)) u_dut3 (
        .clk_i(clk), .rstn_i(rstn),
        .req0_valid_i(v0), .req0_tag_i(t0), .req0_ready_o(r0_w[1]),
        .req1_valid_i(v1), .req1_tag_i(t1), .req1_ready_o(r1_w[1]),
        .hold_i(hold), .mul_valid_o(mv_w[1]), .mul_sel_o(ms_w[1]),
        .wb_valid_o(wv_w[1]), .wb_port_o(wp_w[1]), .wb_tag_o(wt_w[1]),
        .busy_o(bz_w[1])
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expectations whenever a DUT presents a grant or a retiring writeback.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rstn) begin
                chk($sformatf("reset_outs[%0d]", d),
                    int'({r0_w[d], r1_w[d], mv_w[d], ms_w[d], wv_w[d], wp_w[d], wt_w[d], bz_w[d]}), 0);
                m[d] = 0;
                last_sel[d] = 1'b0;
            end else begin
                chk($sformatf("busy[%0d]", d), int'(bz_w[d]), int'(m[d] != 0));
                chk($sformatf("one_ready[%0d]", d), int'(r0_w[d] && r1_w[d]), 0);
                chk($sformatf("mul_valid[%0d]", d), int'(mv_w[d]), int'(r0_w[d] | r1_w[d]));
                if (r0_w[d] || r1_w[d]) begin
                    if (gq[d].size() == 0) begin
                        chk($sformatf("unexpected_grant[%0d]", d), 1, 0);
                    end else begin
                        logic ep;
                        ep = gq[d].pop_front();
                        chk($sformatf("grant_port[%0d]", d), int'(r1_w[d]), int'(ep));
                        chk($sformatf("mul_sel[%0d]", d), int'(ms_w[d]), int'(ep));
                        last_sel[d] = ep;
                    end
                    m[d]++;
                end else begin
                    chk($sformatf("mul_sel_hold[%0d]", d), int'(ms_w[d]), int'(last_sel[d]));
                end
                if (wv_w[d] && !hold) begin
                    if (wbq[d].size() == 0) begin
                        chk($sformatf("unexpected_wb[%0d]", d), 1, 0);
                    end else begin
                        wb_t e;
                        e = wbq[d].pop_front();
                        chk($sformatf("wb_port[%0d]", d), int'(wp_w[d]), int'(e.port));
                        chk($sformatf("wb_tag[%0d]", d), int'(wt_w[d]), int'(e.tag));
                        chk($sformatf("wb_time[%0d]", d), nh, e.nh);
                    end
                    m[d]--;
                end
            end
        end
        if (!hold) nh++;
    end

    task automatic step(input logic a0, input logic [4:0] a_t0, input logic a1, input logic [4:0] a_t1,
                        input logic h, input logic eg, input logic ep, input logic ewb);
        @(posedge clk);
        #1;
        v0 = a0; t0 = a_t0; v1 = a1; t1 = a_t1; hold = h;
        if (eg) begin
            for (int d = 0; d < 2; d++) begin
                gq[d].push_back(ep);
                if (ewb) wbq[d].push_back('{port: ep, tag: (ep ? a_t1 : a_t0), nh: nh + 2 + d});
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    localparam logic [6:0] BUSY2 = 7'b0011110;
    localparam logic [6:0] BUSY3 = 7'b0111110;

    initial begin
        for (int d = 0; d < 2; d++) begin
            m[d] = 0;
            last_sel[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;

        // Contention from reset: round-robin 0,1,0,1 (fixed mode: port 0 every cycle).
        step(1, 5'd1, 1, 5'd2, 0, 1, 1'b0, 1);
        step(1, 5'd1, 1, 5'd2, 0, 1, FIXED ? 1'b0 : 1'b1, 1);
        step(1, 5'd1, 1, 5'd2, 0, 1, 1'b0, 1);
        step(1, 5'd1, 1, 5'd2, 0, 1, FIXED ? 1'b0 : 1'b1, 1);
        idle(4);

        step(1, 5'd5, 0, 5'd0, 0, 1, 1'b0, 1);
        idle(4);

        // Lone requesters win regardless of where priority points.
        step(1, 5'd9, 0, 5'd0, 0, 1, 1'b0, 1);
        step(0, 5'd0, 1, 5'd7, 0, 1, 1'b1, 1);
        step(0, 5'd0, 1, 5'd3, 0, 1, 1'b1, 1);
        idle(4);

        step(0, 5'd0, 1, 5'd12, 0, 1, 1'b1, 1);
        repeat (3) step(1, 5'd20, 1, 5'd21, 1, 0, 1'b0, 0);
        idle(5);

        // Hold while the writeback is already presented.
        step(1, 5'd4, 0, 5'd0, 0, 1, 1'b0, 1);
        idle(1);
        repeat (2) step(1, 5'd20, 1, 5'd21, 1, 0, 1'b0, 0);
        idle(5);

        for (int k = 0; k < 7; k++) begin
            if (k < 3) step(1, 5'd10, 1, 5'd11, 0, 1, (k == 1) ? 1'b0 : (FIXED ? 1'b0 : 1'b1), 1);
            else       idle(1);
            chk($sformatf("busy2_c%0d", k), int'(bz_w[0]), int'(BUSY2[k]));
            chk($sformatf("busy3_c%0d", k), int'(bz_w[1]), int'(BUSY3[k]));
        end
        idle(2);

        // Reset mid-flight drops the pending writeback and restores priority to port 0.
        step(1, 5'd6, 0, 5'd0, 0, 1, 1'b0, 0);
        @(posedge clk);
        #1;
        v0 = 1'b0; v1 = 1'b0; rstn = 1'b0;
        @(negedge clk);
        chk("rst_wb2", int'(wv_w[0]), 0);
        chk("rst_busy3", int'(bz_w[1]), 0);
        @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        idle(5);
        chk("post_rst_busy2", int'(bz_w[0]), 0);
        step(1, 5'd13, 1, 5'd14, 0, 1, 1'b0, 1);
        idle(5);

        for (int d = 0; d < 2; d++) begin
            chk($sformatf("grant_q_empty[%0d]", d), gq[d].size(), 0);
            chk($sformatf("wb_q_empty[%0d]", d), wbq[d].size(), 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mult_sched.md
MULT_SCHED -- requirements
Module: mult_sched

Interface
REQ-001 Parameter MULT_STAGES, default 2, SHALL set the multiplier pipeline depth; legal values 2 or 3.
REQ-002 clk_i  input  1  SHALL be the clock; all state updates on its rising edge.
REQ-003 rstn_i  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 req0_valid_i  input  1  SHALL indicate port 0 (integer issue) has a multiply request pending.
REQ-005 req0_tag_i  input  5  SHALL carry the port-0 destination register index.
REQ-006 req0_ready_o  output  1  SHALL indicate the port-0 request is accepted this cycle.
REQ-007 req1_valid_i / req1_tag_i / req1_ready_o  in/in/out  1/5/1  SHALL be the same as REQ-004..006 for port 1 (secondary requester).
REQ-008 hold_i  input  1  SHALL be the pipeline stall, shared with the multiplier.
REQ-009 mul_valid_o  output  1  SHALL be the issue strobe driven to the multiplier opcode-valid input.
REQ-010 mul_sel_o  output  1  SHALL select the operand/opcode source for the multiplier: 0 = port 0, 1 = port 1.
REQ-011 wb_valid_o  output  1  SHALL mark that the multiplier writeback value is valid this cycle.
REQ-012 wb_port_o  output  1  SHALL identify the port owning the writeback.
REQ-013 wb_tag_o  output  5  SHALL carry the writeback destination tag.
REQ-014 busy_o  output  1  SHALL be high while any operation is in flight.

Function
REQ-015 A grant SHALL occur only in a cycle with hold_i=0; at most one grant per cycle.
REQ-016 The ready output of the granted port SHALL be 1 and the other 0; both SHALL be 0 when hold_i=1 or no request is valid.
REQ-017 When exactly one port is valid, that port SHALL be granted regardless of priority.
REQ-018 When both ports are valid, the port holding priority SHALL win; after any grant to port p, priority SHALL pass to port 1-p.
REQ-019 mul_valid_o SHALL equal (grant this cycle); mul_sel_o SHALL equal the granted port, and hold its last value when no grant occurs.
REQ-020 A tag pipeline of MULT_STAGES entries {valid, port, tag} SHALL capture the grant at entry 1 and shift every cycle with hold_i=0.
REQ-021 With hold_i=1 every tag-pipeline entry and the priority pointer SHALL be frozen.
REQ-022 wb_valid_o/wb_port_o/wb_tag_o SHALL be taken from the last pipeline entry, exactly MULT_STAGES non-held cycles after the grant, aligned with the multiplier result.
REQ-023 A 2-bit in-flight counter SHALL increment on grant and decrement on each clock edge where wb_valid_o=1 and hold_i=0; on a simultaneous grant and retire the count SHALL be unchanged; busy_o = (count != 0).
REQ-024 Back-to-back grants every cycle SHALL be supported with no bubbles.

Reset
REQ-025 With rstn_i=0, all pipeline entries, the counter, mul_sel_o and all outputs SHALL be 0, and priority SHALL be port 0.
REQ-026 An assertion of rstn_i mid-operation SHALL discard all in-flight entries; no wb_valid_o SHALL follow for them.

Configuration
REQ-027 Macro MULT_SCHED_FIXED_PRIO_EN: if defined, port 0 SHALL always win contention and the priority pointer SHALL be removed; if undefined, the round-robin of REQ-018 SHALL apply.

Verification
REQ-028 Port 0 alone, tag=5, MULT_STAGES=2 -> req0_ready_o=1 at cycle 0; wb_valid_o=1, wb_port_o=0, wb_tag_o=5 at cycle 2 only.
REQ-029 Both ports valid for 4 cycles, tags 1/2 -> grants 0,1,0,1; writebacks in the same order with tags 1,2,1,2.
REQ-030 Grant at cycle 0, then hold_i=1 for cycles 1-3 -> wb_valid_o asserts at cycle 5 (2 stages) with the tag unchanged; no ready output during the hold.
REQ-031 MULT_STAGES=3, three consecutive grants -> busy_o=1 from cycle 1 to cycle 5; counter peaks at 3 and returns to 0.
REQ-032 rstn_i pulsed low at cycle 1 after a grant at cycle 0 -> wb_valid_o stays 0 and busy_o=0.
REQ-033 MULT_SCHED_FIXED_PRIO_EN defined, both ports valid -> port 0 granted every cycle; port 1 never ready.
